// File: rtl/keypad_pkg.sv
// Shared constants, debounce state encoding and matrix-position lookup for the keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = 12;

  localparam logic [3:0] KEY_0     = 4'd0;
  localparam logic [3:0] KEY_1     = 4'd1;
  localparam logic [3:0] KEY_2     = 4'd2;
  localparam logic [3:0] KEY_3     = 4'd3;
  localparam logic [3:0] KEY_4     = 4'd4;
  localparam logic [3:0] KEY_5     = 4'd5;
  localparam logic [3:0] KEY_6     = 4'd6;
  localparam logic [3:0] KEY_7     = 4'd7;
  localparam logic [3:0] KEY_8     = 4'd8;
  localparam logic [3:0] KEY_9     = 4'd9;
  localparam logic [3:0] KEY_HASH  = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;
  localparam logic [3:0] CODE_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_CONFIRM_PRESS,
    ST_PRESSED,
    ST_CONFIRM_RELEASE
  } db_state_e;

  // Rows 0-2 are the digit rows 1-3/4-6/7-9; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    case (row)
      2'd0:    idx = KEY_1 + {2'b00, col};
      2'd1:    idx = KEY_4 + {2'b00, col};
      2'd2:    idx = KEY_7 + {2'b00, col};
      default: begin
        case (col)
          2'd0:    idx = KEY_STAR;
          2'd1:    idx = KEY_0;
          default: idx = KEY_HASH;
        endcase
      end
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row drive sequencer, column synchronizer and per-frame closure collector.
// Emits a one-cycle frame_valid on the last dwell cycle of row 3 with the whole-frame verdict.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] col,
  output logic [3:0] row,
  output logic       frame_valid,
  output logic       frame_none,
  output logic       frame_multi,
  output logic [3:0] frame_idx
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    row_q, row_d;
  logic [2:0]    sync1_q, sync2_q;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    idx_q, idx_d;

  logic       dwell_end;
  logic [2:0] closed;
  logic [1:0] row_hits;
  logic [1:0] col_sel;
  logic [2:0] hit_sum;
  logic [1:0] tot_hits;
  logic [3:0] idx_sel;

  always_comb begin
    dwell_end = (div_q == DW'(SCAN_DIV - 1));
    div_d     = dwell_end ? '0 : div_q + DW'(1);
    row_d     = dwell_end ? row_q + 2'd1 : row_q;

    closed   = ~sync2_q;
    row_hits = {1'b0, closed[0]} + {1'b0, closed[1]} + {1'b0, closed[2]};
    col_sel  = closed[0] ? 2'd0 : (closed[1] ? 2'd1 : 2'd2);
    // Hit count saturates at 2: anything beyond one closure is already MULTI.
    hit_sum  = {1'b0, hits_q} + {1'b0, row_hits};
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    idx_sel  = (hits_q == 2'd1) ? idx_q : key_index(row_q, col_sel);

    hits_d = hits_q;
    idx_d  = idx_q;
    if (dwell_end) begin
      if (row_q == 2'd3) begin
        hits_d = 2'd0;
        idx_d  = CODE_NONE;
      end else begin
        hits_d = tot_hits;
        idx_d  = idx_sel;
      end
    end

    frame_valid = dwell_end && (row_q == 2'd3);
    frame_none  = (tot_hits == 2'd0);
    frame_multi = (tot_hits == 2'd2);
    frame_idx   = idx_sel;
    row         = ~(4'b0001 << row_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      row_q   <= 2'd0;
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      hits_q  <= 2'd0;
      idx_q   <= CODE_NONE;
    end else begin
      div_q   <= div_d;
      row_q   <= row_d;
      sync1_q <= col;
      sync2_q <= sync1_q;
      hits_q  <= hits_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad front end: frame debounce FSM producing one-hot Key, binary Code and press/release strobes.
// Optional auto-repeat of key_press while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  Col,
  output logic [3:0]  Row,
  output logic [11:0] Key,
  output logic [3:0]  Code,
  output logic        key_press,
  output logic        key_release
);

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic       frame_valid, frame_none, frame_multi;
  logic [3:0] frame_idx;

  keypad_row_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clock       (clock),
    .reset       (reset),
    .col         (Col),
    .row         (Row),
    .frame_valid (frame_valid),
    .frame_none  (frame_none),
    .frame_multi (frame_multi),
    .frame_idx   (frame_idx)
  );

  db_state_e   state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [11:0] key_q, key_d;
  logic [3:0]  code_q, code_d;
  logic        press_q, press_d, release_q, release_d;

  logic          is_key, hit_cand, accept, drop;
  logic [CW-1:0] cnt_inc;
  logic [RW-1:0] rep_inc;

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    key_d     = key_q;
    code_d    = code_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    accept    = 1'b0;
    drop      = 1'b0;

    is_key   = !frame_none && !frame_multi;
    hit_cand = is_key && (frame_idx == cand_q);
    cnt_inc  = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + CW'(1);
    rep_inc  = rep_q + RW'(1);

    if (frame_valid) begin
      case (state_q)
        ST_RELEASED: begin
          if (is_key) begin
            cand_d = frame_idx;
            cnt_d  = CW'(1);
            if (DEBOUNCE_SCANS == 1) accept = 1'b1;
            else                     state_d = ST_CONFIRM_PRESS;
          end
        end
        ST_CONFIRM_PRESS: begin
          if (hit_cand) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) accept = 1'b1;
          end else if (is_key) begin
            cand_d = frame_idx;
            cnt_d  = CW'(1);
          end else begin
            state_d = ST_RELEASED;
          end
        end
        ST_PRESSED: begin
          if (hit_cand) begin
            // Repeat counter restarts after each pulse, so it never overflows.
            if (rep_inc >= RW'(REPEAT_SCANS)) begin
              rep_d   = '0;
              press_d = REP_EN;
            end else begin
              rep_d = rep_inc;
            end
          end else begin
            rep_d = '0;
            cnt_d = CW'(1);
            if (DEBOUNCE_SCANS == 1) drop = 1'b1;
            else                     state_d = ST_CONFIRM_RELEASE;
          end
        end
        ST_CONFIRM_RELEASE: begin
          if (hit_cand) begin
            state_d = ST_PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE_SCANS)) drop = 1'b1;
          end
        end
        default: state_d = ST_RELEASED;
      endcase
    end

    if (accept) begin
      state_d = ST_PRESSED;
      key_d   = 12'b1 << frame_idx;
      code_d  = frame_idx;
      press_d = 1'b1;
      rep_d   = '0;
    end
    if (drop) begin
      state_d   = ST_RELEASED;
      key_d     = '0;
      code_d    = CODE_NONE;
      release_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RELEASED;
      cand_q    <= CODE_NONE;
      cnt_q     <= '0;
      rep_q     <= '0;
      key_q     <= '0;
      code_q    <= CODE_NONE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      key_q     <= key_d;
      code_q    <= code_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign Key         = key_q;
  assign Code        = code_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule
